// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions: round count, inverse S-box,
// GF(2^8) multiply helpers used by InvMixColumns, and engine FSM states.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    logic [7:0] x2, x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    logic [7:0] x4, x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/aes_inv_mix_col.sv
// InvMixColumns for a single column; row 0 sits in the top byte.
module aes_inv_mix_col
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign col_out[31:24] = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
  assign col_out[23:16] = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
  assign col_out[15:8]  = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
  assign col_out[7:0]   = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);

endmodule

// File: rtl/aes_inv_round_iter.sv
// Iterative AES-128 decryption engine: initial AddRoundKey on accept,
// then one inverse round per clock, fetching round keys via rk_idx/rk_data.
module aes_inv_round_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  fsm_t         fsm, fsm_next;
  logic [127:0] blk;
  logic [3:0]   rnd;
  logic [127:0] subbed, keyed, mixed, round_out;

  // Byte i = 4c+r lives at [127-8i -: 8]; row r pulls from column (c-r) mod 4,
  // then goes through the inverse S-box. Each column then gets InvMixColumns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = 127 - 8 * (4 * c + r);
      localparam int SRC = 127 - 8 * (4 * ((c - r + 4) % 4) + r);
      assign subbed[DST -: 8] = INV_SBOX[blk[SRC -: 8]];
    end
    aes_inv_mix_col u_mix (
      .col_in  (keyed[127 - 32 * c -: 32]),
      .col_out (mixed[127 - 32 * c -: 32])
    );
  end

  assign keyed     = subbed ^ rk_data;
  assign round_out = (rnd == 4'd0) ? keyed : mixed;
  assign out_data  = out_valid ? blk : '0;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_next;
  end

  // Block state and round counter: load on accept, one round per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk <= '0;
      rnd <= '0;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          blk <= in_data ^ rk_data;
          rnd <= 4'(NR - 1);
        end
        RUN: begin
          blk <= round_out;
          if (rnd != 4'd0) rnd <= rnd - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic plus handshake and round-key index outputs.
  always_comb begin
    fsm_next  = fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = 4'd0;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        rk_idx   = 4'(NR);
        if (in_valid) fsm_next = RUN;
      end
      RUN: begin
        rk_idx = rnd;
        if (rnd == 4'd0) fsm_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_inv_round_iter.sv
// Directed bench for the AES-128 inverse round engine using the FIPS-197
// C.1 vector, with a table-based round-key store for key 000102..0f.
module tb_aes_inv_round_iter;

  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [31:0]  mix_in;
  logic [31:0]  mix_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Expanded key schedule for cipher key 000102030405060708090a0b0c0d0e0f.
  function automatic logic [127:0] rk_lookup(input logic [3:0] idx);
    case (idx)
      4'd0:  rk_lookup = 128'h000102030405060708090a0b0c0d0e0f;
      4'd1:  rk_lookup = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
      4'd2:  rk_lookup = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
      4'd3:  rk_lookup = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
      4'd4:  rk_lookup = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
      4'd5:  rk_lookup = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
      4'd6:  rk_lookup = 128'h5e390f7df7a69296a7553dc10aa31f6b;
      4'd7:  rk_lookup = 128'h14f9701ae35fe28c440adf4d4ea9c026;
      4'd8:  rk_lookup = 128'h47438735a41c65b9e016baf4aebf7ad2;
      4'd9:  rk_lookup = 128'h549932d1f08557681093ed9cbe2c974e;
      4'd10: rk_lookup = 128'h13111d7fe3944a17f307a78b4d2b30c5;
      default: rk_lookup = '0;
    endcase
  endfunction

  assign rk_data = rk_lookup(rk_idx);

  aes_inv_round_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  aes_inv_mix_col u_mix (
    .col_in  (mix_in),
    .col_out (mix_out)
  );

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one block at a falling edge; returns one edge after the accept.
  task automatic apply_stimulus(input logic [127:0] ct);
    in_data  = ct;
    in_valid = 1'b1;
    check_output("accept_in_ready", 128'(in_ready), 128'd1);
    check_output("accept_rk_idx", 128'(rk_idx), 128'd10);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    mix_in    = '0;
    #3;
    check_output("rst_in_ready", 128'(in_ready), 128'd1);
    check_output("rst_out_valid", 128'(out_valid), 128'd0);
    check_output("rst_out_data", out_data, 128'd0);
    check_output("rst_rk_idx", 128'(rk_idx), 128'd10);

    mix_in = 32'h8e4da1bc; #1;
    check_output("mix_8e4da1bc", 128'(mix_out), 128'(32'hdb135345));
    mix_in = 32'h9fdc589d; #1;
    check_output("mix_9fdc589d", 128'(mix_out), 128'(32'hf20a225c));
    mix_in = 32'h01010101; #1;
    check_output("mix_01010101", 128'(mix_out), 128'(32'h01010101));

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] C.1 decrypt with round-key index sequence");
    apply_stimulus(CT);
    for (int k = 9; k >= 0; k--) begin
      check_output($sformatf("seq_rk_idx_%0d", k), 128'(rk_idx), 128'(k));
      check_output($sformatf("seq_no_valid_%0d", k), 128'(out_valid), 128'd0);
      @(negedge clk);
    end
    check_output("c1_out_valid", 128'(out_valid), 128'd1);
    check_output("c1_out_data", out_data, PT);
    check_output("c1_done_rk_idx", 128'(rk_idx), 128'd0);
    check_output("c1_done_in_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    check_output("c1_idle_out_valid", 128'(out_valid), 128'd0);
    check_output("c1_idle_in_ready", 128'(in_ready), 128'd1);

    $display("[TB] busy ignore and back-pressure");
    out_ready = 1'b0;
    apply_stimulus(CT);
    repeat (4) @(negedge clk);
    check_output("busy_rk_idx", 128'(rk_idx), 128'd5);
    in_valid = 1'b1;
    in_data  = PT;
    check_output("busy_in_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    check_output("bp_done_reached", 128'(out_valid), 128'd1);
    for (int n = 0; n < 5; n++) begin
      check_output($sformatf("bp_hold_data_%0d", n), out_data, PT);
      check_output($sformatf("bp_hold_in_ready_%0d", n), 128'(in_ready), 128'd0);
      check_output($sformatf("bp_hold_valid_%0d", n), 128'(out_valid), 128'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check_output("bp_release_data", out_data, PT);
    @(negedge clk);
    check_output("bp_idle_out_valid", 128'(out_valid), 128'd0);
    check_output("bp_idle_in_ready", 128'(in_ready), 128'd1);

    $display("[TB] reset mid-run then fresh block");
    apply_stimulus(CT);
    repeat (4) @(negedge clk);
    check_output("mid_rk_idx", 128'(rk_idx), 128'd5);
    #2 rst_n = 1'b0;
    #1;
    check_output("mid_rst_in_ready", 128'(in_ready), 128'd1);
    check_output("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check_output("mid_rst_out_data", out_data, 128'd0);
    check_output("mid_rst_rk_idx", 128'(rk_idx), 128'd10);
    repeat (2) @(negedge clk);
    check_output("mid_rst_hold_valid", 128'(out_valid), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(CT);
    for (int k = 0; k < 10; k++) begin
      check_output($sformatf("post_rst_no_valid_%0d", k), 128'(out_valid), 128'd0);
      @(negedge clk);
    end
    check_output("post_rst_out_valid", 128'(out_valid), 128'd1);
    check_output("post_rst_out_data", out_data, PT);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
